// File: rtl/sub_4bit_serial.sv
// sub_4bit_serial: bit-serial 4-bit subtractor, one bit per clock, LSB first
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           request; a, b, bin captured when accepted (IDLE or DONE)
//   a, b, bin       minuend, subtrahend, borrow-in
//   d, bout, ovf    difference mod 16, unsigned borrow-out, signed overflow
//   busy            high while bits are being processed
//   done            one-cycle result-valid pulse
module sub_4bit_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout,
    output logic       ovf,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state;
    logic [3:0] sa, sb, acc;
    logic [1:0] cnt;
    logic       br, di, br_next, accept;
    assign accept  = start && state != RUN;
    assign di      = sa[0] ^ sb[0] ^ br;
    assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    // acc collects difference bits from the top so it is complete after bit 3;
    // d/bout/ovf load only on the last bit so partial results never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state <= RUN;
                sa    <= a;
                sb    <= b;
                br    <= bin;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (state == RUN) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                br  <= br_next;
                acc <= {di, acc[3:1]};
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    d     <= {di, acc[3:1]};
                    bout  <= br_next;
                    ovf   <= br ^ br_next;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/sub_4bit_serial.md
SUB_4BIT_SERIAL -- requirements
Module: sub_4bit_serial

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, and SHALL list ports clock and reset first:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
REQ-002 The block SHALL provide these ports:
- start  input  1  request; operands sampled when accepted
- a  input  4  minuend, unsigned or two's complement
- b  input  4  subtrahend
- bin  input  1  borrow-in
- d  output  4  difference, a - b - bin mod 16
- bout  output  1  borrow-out; 1 when a < b + bin (unsigned)
- ovf  output  1  signed overflow
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle result-valid pulse

Function
REQ-003 The block SHALL be a bit-serial subtractor that processes one bit per clock, LSB first, through a 1-bit full-subtractor cell and a registered borrow.
REQ-004 The FSM SHALL have the states IDLE, RUN and DONE, with transitions:
- IDLE -> RUN on start
- RUN -> RUN while the bit counter is below 3
- RUN -> DONE after bit 3
- DONE -> RUN on start
- DONE -> IDLE otherwise
REQ-005 The block SHALL accept start only in IDLE or DONE.
- On the accepting edge, capture a, b and bin into internal shift/borrow registers.
- Clear the bit counter to 0.
REQ-006 The block SHALL ignore start while in RUN: no operand capture, and no effect on the operation in progress.
REQ-007 The block SHALL compute bit i in RUN as follows:
- d_i = a_i ^ b_i ^ br
- br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
- br starts at the captured bin.
REQ-008 Latency: for an accepting edge T0, the block SHALL process bits 0..3 on edges T1..T4.
- d, bout and ovf SHALL update on T4.
- done SHALL be high for exactly the cycle between T4 and T5.
REQ-009 busy SHALL be 1 exactly while in RUN: after T0 through T4. It SHALL be 0 in IDLE and DONE.
REQ-010 d, bout and ovf SHALL hold their last result until the next T4 update, and SHALL never show partial results during RUN.
REQ-011 The output values SHALL be:
- bout = borrow out of bit 3
- ovf = (borrow into bit 3) XOR (borrow out of bit 3)
REQ-012 Back-to-back operation: start high during the DONE cycle SHALL be accepted at T5, with the next done at T9. A throughput of one result per 5 cycles SHALL be sustained.
REQ-013 Operand inputs a, b and bin SHALL be don't-care except at an accepting edge.

Reset
REQ-014 While rst_n = 0, the block SHALL asynchronously force:
- state = IDLE, counter = 0, internal registers = 0
- d = 4'b0000, bout = 0, ovf = 0, busy = 0, done = 0
REQ-015 Reset asserted mid-RUN SHALL abort the operation: no done pulse and no output update for that operation.
REQ-016 After rst_n deasserts, the first rising edge with start = 1 SHALL be accepted normally.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
- a=5, b=3, bin=0, start pulse at T0 -> busy cycles T0..T4, done after T4; d=0010, bout=0, ovf=0.
- a=0, b=1, bin=0 -> d=1111, bout=1, ovf=0; a=0, b=0, bin=1 -> d=1111, bout=1.
- a=1000 (-8), b=0001, bin=0 -> d=0111, bout=0, ovf=1; a=0111, b=1111 -> d=1000, ovf=1, bout=1.
- Start with a=9, b=2, then start again with a=1, b=1 at T2 (busy) -> second start ignored; result d=0111 at T4, and no second done.
- Start at T0, rst_n low between T2 and T3 -> all outputs 0 immediately, no done; a new start after release gives the correct result 4 cycles later.
- Exhaustive: all 512 {bin, b, a} combinations issued back-to-back (start held high) -> each done returns d = (a - b - bin) mod 16, bout = (a < b + bin), with done every 5 cycles.
